ddr_wr_sched: RTL and testbench
===============================

DDR_WR_SCHED -- requirements
Module: ddr_wr_sched

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 128: width of one packed word and one AXI beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-003 SHALL have parameter BURST_LEN, default 16: beats per full burst, 1..256.
REQ-004 SHALL have parameter BASE_ADDR, default 0: ring start, aligned to BURST_LEN*WORD_WIDTH/8.
REQ-005 SHALL have parameter BUF_BYTES, default 4096: ring size, a multiple of the burst bytes.
REQ-006 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, reset, synchronous, active-low.
REQ-007 SHALL have ports: enable in 1; flush in 1; fifo_data in WORD_WIDTH, first-word-fall-through head of the word FIFO; fifo_count in 9, words available; fifo_rd_en out 1, pop.
REQ-008 SHALL have AXI write-address ports: awaddr out ADDR_WIDTH; awlen out 8; awsize out 3; awburst out 2; awvalid out 1; awready in 1.
REQ-009 SHALL have AXI write-data ports: wdata out WORD_WIDTH; wstrb out WORD_WIDTH/8; wlast out 1; wvalid out 1; wready in 1.
REQ-010 SHALL have AXI write-response ports: bresp in 2; bvalid in 1; bready out 1.
REQ-011 SHALL have status ports: busy out 1; bursts_done out 16; err out 1.

Function
REQ-012 SHALL implement FSM states IDLE, AW, W, B.
REQ-013 IDLE->AW SHALL occur when enable=1 and fifo_count>=BURST_LEN; the latched beat count is BURST_LEN.
REQ-014 In AW, awvalid=1 SHALL hold, with awaddr/awlen stable, until awready; then ->W on the next cycle.
REQ-015 awlen SHALL be latched beats-1; awsize SHALL be log2(WORD_WIDTH/8); awburst SHALL be INCR (2'b01).
REQ-016 In W: wvalid=1, wdata=fifo_data, wstrb all ones, fifo_rd_en=wvalid&wready (combinational, pop only on handshake).
REQ-017 The beat counter SHALL increment per W handshake; wlast=1 SHALL be asserted exactly on the final beat; ->B after the final handshake.
REQ-018 wready low SHALL stall the beat with wdata held; no pop, no count change.
REQ-019 In B, bready=1; on bvalid: ->IDLE, bursts_done+1 (wraps modulo 2^16), and address advance by beats*WORD_WIDTH/8.
REQ-020 If advanced address >= BASE_ADDR+BUF_BYTES, the address SHALL wrap to BASE_ADDR.
REQ-021 bresp!=2'b00 SHALL set err sticky until reset; the address still advances.
REQ-022 enable deasserted mid-burst SHALL have no effect until return to IDLE; the started burst always completes.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 No AXI output SHALL change while its valid is high and ready is low.

Reset
REQ-025 With rst_n=0 at clk edge: state IDLE, address BASE_ADDR, beat counter 0, bursts_done 0, err 0.
REQ-026 During reset, all valids, bready, fifo_rd_en, wlast and busy SHALL be 0.
REQ-027 Reset mid-burst SHALL abandon the transaction immediately; no further FIFO pops occur.

Configuration
REQ-028 Macro DDR_WR_SCHED_FLUSH_EN defined: in IDLE with flush=1, enable=1 and 0<fifo_count<BURST_LEN, IDLE->AW with beats=fifo_count, awlen=fifo_count-1; the address advances by beats*WORD_WIDTH/8 and wraps per REQ-020.
REQ-029 Macro undefined: the flush port SHALL remain present but be ignored; only full bursts are issued.

Structure
REQ-030 Package ddr_wr_pkg SHALL hold: FSM state enum; AXI_BURST_INCR, AXI_RESP_OKAY constants; awsize derivation function.
REQ-031 Sub-module ddr_wr_addr_gen SHALL hold the address register, advance and ring wrap; the FSM, beat counter and status stay in ddr_wr_sched.

Verification
REQ-032 Basic: fifo_count=16, enable=1, all readies 1 -> one AW at 0x0, awlen=15, 16 beats, wlast on beat 16, 16 pops, bursts_done=1.
REQ-033 Back-pressure: wready toggled 1-0 every cycle -> wdata held on stall cycles, exactly 16 pops, data order preserved.
REQ-034 Wrap: 16 consecutive full bursts, BUF_BYTES=4096 -> awaddr 0x000,0x100,...,0xF00 then 0x000 on burst 17.
REQ-035 Error: bresp=2'b10 on burst 1 -> err=1 persists; burst 2 issued at 0x100.
REQ-036 Flush (macro on): fifo_count=5, flush=1 -> awlen=4, 5 beats, next awaddr 0x050.
REQ-037 Reset mid-W after beat 7 -> state IDLE, awvalid=wvalid=0, no pop on the following cycle, awaddr restarts at BASE_ADDR.

Source files
------------

// File: rtl/ddr_wr_pkg.sv
// Shared types and AXI constants for the DDR ring-buffer write scheduler.
package ddr_wr_pkg;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AxSIZE encoding: log2 of bytes per beat
  function automatic logic [2:0] axi_size(input int bytes);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      if ((1 << i) == bytes) s = 3'(i);
    return s;
  endfunction

endpackage

// File: rtl/ddr_wr_addr_gen.sv
// Ring-buffer write address: holds the next burst address, advances per
// completed burst and wraps back to the ring base.
module ddr_wr_addr_gen #(
  parameter int unsigned             WORD_WIDTH = 128,
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
  parameter int unsigned             BUF_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adv_i,
  input  logic [8:0]            beats_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  // One extra bit so base+size and the advanced address never overflow
  localparam logic [ADDR_WIDTH:0] RING_END = AW1'(BASE_ADDR) + AW1'(BUF_BYTES);
  localparam logic [ADDR_WIDTH:0] BEAT_B   = AW1'(WORD_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   next_w;

  assign next_w = {1'b0, addr_q} + AW1'(beats_i) * BEAT_B;
  assign addr_d = (next_w >= RING_END) ? BASE_ADDR : next_w[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n)     addr_q <= BASE_ADDR;
    else if (adv_i) addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/ddr_wr_sched.sv
// Drains a FWFT word FIFO into a DDR ring buffer as AXI INCR write bursts.
// Optional DDR_WR_SCHED_FLUSH_EN: issue a short burst of the residual words on flush.
module ddr_wr_sched
  import ddr_wr_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH = 128,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           BURST_LEN  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           BUF_BYTES  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [WORD_WIDTH-1:0]   fifo_data,
  input  logic [8:0]              fifo_count,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [WORD_WIDTH-1:0]   wdata,
  output logic [WORD_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    busy,
  output logic [15:0]             bursts_done,
  output logic                    err
);

  localparam logic [2:0] AWSIZE = axi_size(WORD_WIDTH / 8);

  wr_state_e   state_q;
  logic [8:0]  beats_q, beat_cnt_q, start_beats;
  logic [7:0]  awlen_q;
  logic [15:0] bursts_q;
  logic        awvalid_q, wvalid_q, bready_q, busy_q, err_q;
  logic        full_ok, flush_ok, last_beat, adv;

  assign full_ok = fifo_count >= 9'(BURST_LEN);

`ifdef DDR_WR_SCHED_FLUSH_EN
  assign flush_ok = flush && (fifo_count != 9'd0) && !full_ok;
`else
  logic flush_unused;
  assign flush_unused = flush;
  assign flush_ok     = 1'b0;
`endif

  assign start_beats = full_ok ? 9'(BURST_LEN) : fifo_count;
  assign last_beat   = beat_cnt_q == (beats_q - 9'd1);
  assign adv         = (state_q == S_B) && bvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      awlen_q    <= '0;
      bursts_q   <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (enable && (full_ok || flush_ok)) begin
          beats_q    <= start_beats;
          awlen_q    <= 8'(start_beats - 9'd1);
          beat_cnt_q <= '0;
          awvalid_q  <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= S_AW;
        end
        S_AW: if (awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          state_q   <= S_W;
        end
        S_W: if (wready) begin
          beat_cnt_q <= beat_cnt_q + 9'd1;
          if (last_beat) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: if (bvalid) begin
          bready_q <= 1'b0;
          busy_q   <= 1'b0;
          bursts_q <= bursts_q + 16'd1;
          if (bresp != AXI_RESP_OKAY) err_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  ddr_wr_addr_gen #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .BUF_BYTES  (BUF_BYTES)
  ) u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_i   (adv),
    .beats_i (beats_q),
    .addr_o  (awaddr)
  );

  // Handshake outputs are forced low while reset is held so a burst is
  // dropped on the spot and the FIFO sees no pop in that cycle.
  assign awvalid     = awvalid_q & rst_n;
  assign wvalid      = wvalid_q & rst_n;
  assign bready      = bready_q & rst_n;
  assign busy        = busy_q & rst_n;
  assign wlast       = wvalid & last_beat;
  assign fifo_rd_en  = wvalid & wready;
  assign awlen       = awlen_q;
  assign awsize      = AWSIZE;
  assign awburst     = AXI_BURST_INCR;
  assign wdata       = fifo_data;
  assign wstrb       = '1;
  assign bursts_done = bursts_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ddr_wr_sched.sv
// Directed bench for ddr_wr_sched: FWFT FIFO model, AXI slave stub, handshake monitor.
module tb_ddr_wr_sched;

  logic         clk = 1'b0;
  logic         rst_n, enable, flush;
  logic [127:0] fifo_data;
  logic [8:0]   fifo_count;
  logic         fifo_rd_en;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready, busy, err;
  logic [15:0]  bursts_done;

  always #5 clk = ~clk;

  ddr_wr_sched dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_data(fifo_data), .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .bursts_done(bursts_done), .err(err)
  );

  // FIFO model: word i of the stream is mem[i]; pushed written by stimulus, pops by monitor
  logic [127:0] mem [0:1023];
  int pushed = 0;
  int pops   = 0;
  assign fifo_count = 9'(pushed - pops);
  assign fifo_data  = mem[pops[9:0]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor
  logic [31:0]  aw_addr_q [$];
  logic [7:0]   aw_len_q  [$];
  int           blen_q    [$];
  logic [2:0]   aw_size_l = '0;
  logic [1:0]   aw_burst_l = '0;
  int           bcnt = 0, w_bad = 0, hold_bad = 0, stalls = 0;
  logic         aw_stall = 1'b0, w_stall = 1'b0;
  logic [31:0]  aw_hold_a = '0;
  logic [7:0]   aw_hold_l = '0;
  logic [127:0] w_hold_d = '0;
  logic         w_hold_l = 1'b0;

  always @(posedge clk) begin
    if (fifo_rd_en) pops <= pops + 1;
    if (awvalid && awready) begin
      aw_addr_q.push_back(awaddr);
      aw_len_q.push_back(awlen);
      aw_size_l  <= awsize;
      aw_burst_l <= awburst;
    end
    if (!rst_n) bcnt <= 0;
    else if (wvalid && wready) begin
      if (wdata !== mem[pops[9:0]] || wstrb !== 16'hFFFF) w_bad <= w_bad + 1;
      if (wlast) begin
        blen_q.push_back(bcnt + 1);
        bcnt <= 0;
      end else bcnt <= bcnt + 1;
    end
    if ((aw_stall && (!awvalid || awaddr !== aw_hold_a || awlen !== aw_hold_l)) ||
        (w_stall && (!wvalid || wdata !== w_hold_d || wlast !== w_hold_l)))
      hold_bad <= hold_bad + 1;
    aw_stall  <= rst_n && awvalid && !awready;
    aw_hold_a <= awaddr;
    aw_hold_l <= awlen;
    w_stall   <= rst_n && wvalid && !wready;
    w_hold_d  <= wdata;
    w_hold_l  <= wlast;
    if (rst_n && wvalid && !wready) stalls <= stalls + 1;
  end

  task automatic wait_done(input int target, input int maxc, input bit tog);
    int c;
    c = 0;
    while (bursts_done != 16'(target) && c < maxc) begin
      @(negedge clk);
      if (tog) wready = ~wready;
      c++;
    end
    wready = 1'b1;
    chk("burst_done", 128'(bursts_done), 128'(target));
  endtask

  initial begin
    int p0, c;
    for (int i = 0; i < 1024; i++) mem[i] = {4{32'(i) ^ 32'h5A5A_0000}};
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_awvalid", 128'(awvalid), 128'(0));
    chk("rst_wvalid", 128'(wvalid), 128'(0));
    chk("rst_bready", 128'(bready), 128'(0));
    chk("rst_rd_en", 128'(fifo_rd_en), 128'(0));
    chk("rst_bursts", 128'(bursts_done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_addr", 128'(awaddr), 128'(0));
    rst_n = 1'b1;

    // Burst 1: AW held off by awready, slave returns SLVERR
    awready = 1'b0; bresp = 2'b10; pushed = 16; enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("aw_wait_valid", 128'(awvalid), 128'(1));
    chk("aw_wait_busy", 128'(busy), 128'(1));
    awready = 1'b1;
    wait_done(1, 500, 1'b0);
    bresp = 2'b00;
    chk("b1_aw_cnt", 128'(aw_addr_q.size()), 128'(1));
    chk("b1_addr", 128'(aw_addr_q[0]), 128'(0));
    chk("b1_awlen", 128'(aw_len_q[0]), 128'(15));
    chk("b1_awsize", 128'(aw_size_l), 128'(4));
    chk("b1_awburst", 128'(aw_burst_l), 128'(1));
    chk("b1_wlast_pos", 128'(blen_q[0]), 128'(16));
    chk("b1_pops", 128'(pops), 128'(16));
    chk("b1_err", 128'(err), 128'(1));

    // Burst 2: wready toggling every cycle
    pushed += 16;
    wait_done(2, 500, 1'b1);
    chk("bp_addr", 128'(aw_addr_q[1]), 128'(32'h100));
    chk("bp_wlast_pos", 128'(blen_q[1]), 128'(16));
    chk("bp_pops", 128'(pops), 128'(32));
    chk("bp_stalled", 128'(stalls > 0), 128'(1));
    chk("bp_err_sticky", 128'(err), 128'(1));

    // Bursts 3..17: ring of 4096 bytes wraps after 16 bursts
    pushed += 240;
    wait_done(17, 8000, 1'b0);
    for (int i = 0; i < 17; i++)
      chk("wrap_addr", 128'(aw_addr_q[i]), 128'((i * 256) % 4096));
    chk("wrap_pops", 128'(pops), 128'(272));
    chk("wrap_err", 128'(err), 128'(1));

    // Burst 18: enable dropped once W is running; burst still completes
    pushed += 16;
    c = 0;
    while (!wvalid && c < 100) begin @(negedge clk); c++; end
    chk("en_drop_wvalid", 128'(wvalid), 128'(1));
    enable = 1'b0;
    wait_done(18, 500, 1'b0);
    chk("en_drop_addr", 128'(aw_addr_q[17]), 128'(32'h100));
    chk("en_drop_len", 128'(blen_q[17]), 128'(16));
    chk("en_drop_pops", 128'(pops), 128'(288));
    chk("en_drop_idle", 128'(busy), 128'(0));

    // Reset after beat 7 of a burst
    enable = 1'b1; pushed += 16; p0 = pops; c = 0;
    while (pops - p0 < 7 && c < 200) begin @(negedge clk); c++; end
    chk("mid_beats", 128'(pops - p0), 128'(7));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wvalid", 128'(wvalid), 128'(0));
    chk("mid_rst_awvalid", 128'(awvalid), 128'(0));
    chk("mid_rst_rd_en", 128'(fifo_rd_en), 128'(0));
    p0 = pops;
    @(negedge clk);
    chk("mid_rst_nopop", 128'(pops), 128'(p0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_addr", 128'(awaddr), 128'(0));
    chk("mid_rst_bursts", 128'(bursts_done), 128'(0));
    chk("mid_rst_err", 128'(err), 128'(0));
    pushed = pops;
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DDR_WR_SCHED_FLUSH_EN
    // Flush of 5 residual words, then a full burst after it
    pushed += 5; flush = 1'b1;
    wait_done(1, 500, 1'b0);
    flush = 1'b0;
    chk("flush_awlen", 128'(aw_len_q[$]), 128'(4));
    chk("flush_beats", 128'(blen_q[$]), 128'(5));
    pushed += 16;
    wait_done(2, 500, 1'b0);
    chk("flush_next_addr", 128'(aw_addr_q[$]), 128'(32'h50));
`else
    // Flush ignored: 5 words never start a burst, 16 do
    p0 = aw_addr_q.size();
    pushed += 5; flush = 1'b1;
    repeat (40) @(negedge clk);
    chk("noflush_busy", 128'(busy), 128'(0));
    chk("noflush_aw", 128'(aw_addr_q.size()), 128'(p0));
    flush = 1'b0; pushed += 11;
    wait_done(1, 500, 1'b0);
    chk("noflush_awlen", 128'(aw_len_q[$]), 128'(15));
    chk("noflush_addr", 128'(aw_addr_q[$]), 128'(0));
`endif

    chk("data_order", 128'(w_bad), 128'(0));
    chk("axi_hold", 128'(hold_bad), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
